// File: rtl/cabac_level_decoder.sv
// CABAC coefficient level decoder: consumes greater1/greater2/Golomb-Rice bins one per cycle,
// rebuilds the absolute level and keeps the c1/c2/c1Idx/c2Idx/Rice context in step with the encoder.
module cabac_level_decoder #(
  parameter int unsigned C1_WIDTH    = 2,
  parameter int unsigned C2_WIDTH    = 2,
  parameter int unsigned C1IDX_WIDTH = 4,
  parameter int unsigned C2IDX_WIDTH = 5,
  parameter int unsigned GR_WIDTH    = 3,
  parameter int unsigned LEVEL_WIDTH = 16,
  parameter int unsigned C1FLAG_NUM  = 8,
  parameter int unsigned C2FLAG_NUM  = 1,
  parameter int unsigned MAX_PREFIX  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_sig,
  input  logic                   cmd_cg_start,
  input  logic [GR_WIDTH-1:0]    initial_gr,
  input  logic                   bin_valid,
  output logic                   bin_ready,
  input  logic                   bin,
  output logic                   lvl_valid,
  input  logic                   lvl_ready,
  output logic [LEVEL_WIDTH-1:0] lvl_value,
  output logic                   lvl_err,
  output logic [C1_WIDTH-1:0]    c1_out,
  output logic [C2_WIDTH-1:0]    c2_out,
  output logic [C1IDX_WIDTH-1:0] c1Idx_out,
  output logic [C2IDX_WIDTH-1:0] c2Idx_out,
  output logic [GR_WIDTH-1:0]    uiGoRice_out
);

  localparam int unsigned PW = $clog2(MAX_PREFIX + 1);
  localparam int unsigned SW = MAX_PREFIX;
  localparam int unsigned CW = $clog2(SW + 1);
  localparam int unsigned XW = LEVEL_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_G1, S_G2, S_PREFIX, S_SUFFIX, S_OUT
  } state_e;

  state_e                 state_q;
  logic [C1_WIDTH-1:0]    c1_q;
  logic [C2_WIDTH-1:0]    c2_q;
  logic [C1IDX_WIDTH-1:0] c1idx_q;
  logic [C2IDX_WIDTH-1:0] c2idx_q;
  logic [GR_WIDTH-1:0]    gr_q;
  logic [1:0]             base_q;
  logic [PW-1:0]          pcnt_q;
  logic [CW-1:0]          scnt_q;
  logic [SW-1:0]          s_q;
  logic                   cmd_ready_q;
  logic                   bin_ready_q;
  logic                   lvl_valid_q;
  logic [LEVEL_WIDTH-1:0] lvl_value_q;
  logic                   lvl_err_q;

  logic                   fin_c;
  logic [LEVEL_WIDTH-1:0] fin_lvl_c;
  logic                   fin_err_c;
  logic [SW-1:0]          s_next_c;
  logic [PW-1:0]          pcnt_inc_c;
  logic [CW-1:0]          nbits_c;
  logic [C1IDX_WIDTH-1:0] c1idx_eff_c;

  // base + Golomb-Rice remainder, evaluated two bits wider than the level and saturated
  function automatic logic [LEVEL_WIDTH-1:0] calc_level(input logic [1:0]          base,
                                                         input logic [PW-1:0]       p,
                                                         input logic [GR_WIDTH-1:0] k,
                                                         input logic [SW-1:0]       s);
    logic [XW-1:0] rem;
    logic [XW-1:0] lvl;
    if (p < PW'(3)) rem = (XW'(p) << k) + XW'(s);
    else            rem = (((XW'(1) << (p - PW'(3))) + XW'(2)) << k) + XW'(s);
    lvl = rem + XW'(base);
    if (lvl > XW'({LEVEL_WIDTH{1'b1}})) calc_level = '1;
    else                                calc_level = lvl[LEVEL_WIDTH-1:0];
  endfunction

  // Bin-driven completion: which consumed bin ends the coefficient and with what level
  always_comb begin
    fin_c       = 1'b0;
    fin_lvl_c   = '0;
    fin_err_c   = 1'b0;
    s_next_c    = SW'({s_q, bin});
    pcnt_inc_c  = pcnt_q + PW'(1);
    nbits_c     = (pcnt_q < PW'(3)) ? CW'(gr_q) : CW'(pcnt_q) - CW'(3) + CW'(gr_q);
    c1idx_eff_c = cmd_cg_start ? '0 : c1idx_q;
    if (bin_valid && bin_ready_q) begin
      case (state_q)
        S_G1: if (!bin) begin
          fin_c     = 1'b1;
          fin_lvl_c = LEVEL_WIDTH'(1);
        end
        S_G2: if (!bin) begin
          fin_c     = 1'b1;
          fin_lvl_c = LEVEL_WIDTH'(2);
        end
        S_PREFIX: begin
          if (bin && (pcnt_inc_c == PW'(MAX_PREFIX))) begin
            fin_c     = 1'b1;
            fin_err_c = 1'b1;
            fin_lvl_c = '1;
          end else if (!bin && (nbits_c == '0)) begin
            fin_c     = 1'b1;
            fin_lvl_c = calc_level(base_q, pcnt_q, gr_q, '0);
          end
        end
        S_SUFFIX: if (scnt_q == CW'(1)) begin
          fin_c     = 1'b1;
          fin_lvl_c = calc_level(base_q, pcnt_q, gr_q, s_next_c);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      c1_q        <= C1_WIDTH'(1);
      c2_q        <= '0;
      c1idx_q     <= '0;
      c2idx_q     <= '0;
      gr_q        <= '0;
      base_q      <= 2'd1;
      pcnt_q      <= '0;
      scnt_q      <= '0;
      s_q         <= '0;
      cmd_ready_q <= 1'b1;
      bin_ready_q <= 1'b0;
      lvl_valid_q <= 1'b0;
      lvl_value_q <= '0;
      lvl_err_q   <= 1'b0;
    end else if (fin_c) begin
      state_q     <= S_OUT;
      bin_ready_q <= 1'b0;
      lvl_valid_q <= 1'b1;
      lvl_value_q <= fin_lvl_c;
      lvl_err_q   <= fin_err_c;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          cmd_ready_q <= 1'b0;
          base_q      <= 2'd1;
          pcnt_q      <= '0;
          s_q         <= '0;
          if (cmd_cg_start) begin
            c1_q    <= C1_WIDTH'(1);
            c2_q    <= '0;
            c1idx_q <= '0;
            c2idx_q <= '0;
            gr_q    <= initial_gr;
          end
          if (!cmd_sig) begin
            state_q     <= S_OUT;
            lvl_valid_q <= 1'b1;
            lvl_value_q <= '0;
            lvl_err_q   <= 1'b0;
          end else begin
            state_q     <= (32'(c1idx_eff_c) < C1FLAG_NUM) ? S_G1 : S_PREFIX;
            bin_ready_q <= 1'b1;
          end
        end
        S_G1: if (bin_valid) begin
          if (32'(c2idx_q) < C2FLAG_NUM) begin
            state_q <= S_G2;
          end else begin
            base_q  <= 2'd2;
            state_q <= S_PREFIX;
          end
        end
        S_G2: if (bin_valid) begin
          base_q  <= 2'd3;
          state_q <= S_PREFIX;
        end
        S_PREFIX: if (bin_valid) begin
          if (bin) begin
            pcnt_q <= pcnt_inc_c;
          end else begin
            scnt_q  <= nbits_c;
            state_q <= S_SUFFIX;
          end
        end
        S_SUFFIX: if (bin_valid) begin
          s_q    <= s_next_c;
          scnt_q <= scnt_q - CW'(1);
        end
        S_OUT: if (lvl_ready) begin
          lvl_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
          // An errored level leaves the context untouched
          if (!lvl_err_q) begin
            if (lvl_value_q > LEVEL_WIDTH'(1)) begin
              c1_q <= '0;
              if (c2_q < C2_WIDTH'(2)) c2_q <= c2_q + C2_WIDTH'(1);
              if (c2idx_q != '1) c2idx_q <= c2idx_q + C2IDX_WIDTH'(1);
            end else if ((c1_q != '0) && (c1_q < C1_WIDTH'(3)) && (lvl_value_q != '0)) begin
              c1_q <= c1_q + C1_WIDTH'(1);
            end
            if ((lvl_value_q != '0) && (c1idx_q != '1)) c1idx_q <= c1idx_q + C1IDX_WIDTH'(1);
            if (XW'(lvl_value_q) >= (XW'(3) << gr_q))
              gr_q <= (gr_q >= GR_WIDTH'(4)) ? GR_WIDTH'(4) : gr_q + GR_WIDTH'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign bin_ready    = bin_ready_q;
  assign lvl_valid    = lvl_valid_q;
  assign lvl_value    = lvl_value_q;
  assign lvl_err      = lvl_err_q;
  assign c1_out       = c1_q;
  assign c2_out       = c2_q;
  assign c1Idx_out    = c1idx_q;
  assign c2Idx_out    = c2idx_q;
  assign uiGoRice_out = gr_q;

endmodule

// File: tb/tb_cabac_level_decoder.sv
// Scoreboard bench for cabac_level_decoder: a behavioural level/context model feeds an expected
// queue at stimulus time; a negedge monitor pops and compares each output beat.
module tb_cabac_level_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_sig, cmd_cg_start;
  logic [2:0]  initial_gr;
  logic        bin_valid, bin;
  logic        lvl_ready;
  logic        cmd_ready, bin_ready, lvl_valid, lvl_err;
  logic [15:0] lvl_value;
  logic [1:0]  c1_out, c2_out;
  logic [3:0]  c1Idx_out;
  logic [4:0]  c2Idx_out;
  logic [2:0]  uiGoRice_out;

  always #5 clk = ~clk;

  cabac_level_decoder dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sig(cmd_sig),
    .cmd_cg_start(cmd_cg_start), .initial_gr(initial_gr),
    .bin_valid(bin_valid), .bin_ready(bin_ready), .bin(bin),
    .lvl_valid(lvl_valid), .lvl_ready(lvl_ready), .lvl_value(lvl_value), .lvl_err(lvl_err),
    .c1_out(c1_out), .c2_out(c2_out), .c1Idx_out(c1Idx_out), .c2Idx_out(c2Idx_out),
    .uiGoRice_out(uiGoRice_out)
  );

  typedef struct packed {
    logic [15:0] lvl;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  bit   bq[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   beats = 0;
  int   br_cycles = 0;
  int   m_c1, m_c2, m_c1i, m_c2i, m_gr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  // Output monitor: one beat per negedge with valid & ready, compared to the queue head
  always @(negedge clk) begin
    exp_t e;
    if (bin_ready === 1'b1) br_cycles++;
    if (!rst && lvl_valid && lvl_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(lvl_value), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("lvl_value", 32'(lvl_value), 32'(e.lvl));
        check("lvl_err", 32'(lvl_err), 32'(e.err));
      end
      beats++;
    end
  end

  task automatic model_reset();
    m_c1 = 1; m_c2 = 0; m_c1i = 0; m_c2i = 0; m_gr = 0;
  endtask

  // Reference decode of one coefficient from bq; returns level, error and bins consumed
  task automatic model_coef(input bit cg, input int igr, input bit sig,
                            output int lvl, output bit err, output int nb);
    int idx = 0;
    int base = 1;
    int p = 0;
    int n, s, rem;
    bit b;
    bit pre = 1'b1;
    if (cg) begin
      m_c1 = 1; m_c2 = 0; m_c1i = 0; m_c2i = 0; m_gr = igr;
    end
    err = 1'b0;
    lvl = 0;
    if (sig) begin
      if (m_c1i < 8) begin
        b = bq[idx]; idx++;
        if (!b) begin
          lvl = 1; pre = 1'b0;
        end else if (m_c2i < 1) begin
          b = bq[idx]; idx++;
          if (!b) begin lvl = 2; pre = 1'b0; end
          else base = 3;
        end else begin
          base = 2;
        end
      end
      if (pre) begin
        while (!err) begin
          b = bq[idx]; idx++;
          if (!b) break;
          p++;
          if (p == 12) err = 1'b1;
        end
        if (err) begin
          lvl = 65535;
        end else begin
          n = (p < 3) ? m_gr : p - 3 + m_gr;
          s = 0;
          for (int i = 0; i < n; i++) begin
            s = s * 2 + int'(bq[idx]); idx++;
          end
          rem = (p < 3) ? p * (1 << m_gr) + s : ((1 << (p - 3)) + 2) * (1 << m_gr) + s;
          lvl = base + rem;
          if (lvl > 65535) lvl = 65535;
        end
      end
    end
    nb = idx;
    if (!err) begin
      if (lvl > 1) begin
        m_c1 = 0;
        if (m_c2 < 2) m_c2++;
        if (m_c2i < 31) m_c2i++;
      end else if (m_c1 > 0 && m_c1 < 3 && lvl != 0) begin
        m_c1++;
      end
      if (lvl > 0 && m_c1i < 15) m_c1i++;
      if (lvl >= 3 * (1 << m_gr)) m_gr = (m_gr >= 4) ? 4 : m_gr + 1;
    end
  endtask

  task automatic pad_bq();
    while (bq.size() < 40) bq.push_back(1'b0);
  endtask

  // Drive one coefficient: command, bins (optionally with a dead cycle before each), output beat
  task automatic do_coef(input bit cg, input int igr, input bit sig, input bit stall, input int hold);
    int  lvl, nb, t, b0, br0;
    bit  err;
    exp_t e;
    model_coef(cg, igr, sig, lvl, err, nb);
    e.lvl = 16'(lvl);
    e.err = err;
    exp_q.push_back(e);
    b0  = beats;
    br0 = br_cycles;
    lvl_ready    = (hold == 0);
    cmd_valid    = 1'b1;
    cmd_sig      = sig;
    cmd_cg_start = cg;
    initial_gr   = 3'(igr);
    t = 0;
    while (!cmd_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_cg_start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (stall) begin
        bin_valid = 1'b0; bin = ~bq[i];
        @(posedge clk); #1;
      end
      bin = bq[i]; bin_valid = 1'b1;
      t = 0;
      while (!bin_ready && t < 20) begin @(posedge clk); #1; t++; end
      if (!bin_ready) check("bin_ready_timeout", 32'(bin_ready), 32'd1);
      @(posedge clk); #1;
    end
    bin_valid = 1'b0;
    check("lvl_latency", 32'(lvl_valid), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(lvl_valid), 32'd1);
      check("hold_value", 32'(lvl_value), 32'(e.lvl));
      check("hold_err", 32'(lvl_err), 32'(e.err));
      check("hold_bin_ready", 32'(bin_ready), 32'd0);
    end
    lvl_ready = 1'b1;
    t = 0;
    while (beats == b0 && t < 20) begin @(posedge clk); #1; t++; end
    if (beats == b0) begin
      check("lvl_beat_timeout", 32'(beats), 32'(b0 + 1));
      exp_q.delete();
    end
    if (!stall) check("bin_ready_cycles", 32'(br_cycles - br0), 32'(nb));
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_lvl_valid", 32'(lvl_valid), 32'd0);
    check("c1", 32'(c1_out), 32'(m_c1));
    check("c2", 32'(c2_out), 32'(m_c2));
    check("c1Idx", 32'(c1Idx_out), 32'(m_c1i));
    check("c2Idx", 32'(c2Idx_out), 32'(m_c2i));
    check("gr", 32'(uiGoRice_out), 32'(m_gr));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_lvl_valid"}, 32'(lvl_valid), 32'd0);
    check({tag, "_lvl_value"}, 32'(lvl_value), 32'd0);
    check({tag, "_lvl_err"}, 32'(lvl_err), 32'd0);
    check({tag, "_bin_ready"}, 32'(bin_ready), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_c1"}, 32'(c1_out), 32'd1);
    check({tag, "_c2"}, 32'(c2_out), 32'd0);
    check({tag, "_c1Idx"}, 32'(c1Idx_out), 32'd0);
    check({tag, "_c2Idx"}, 32'(c2Idx_out), 32'd0);
    check({tag, "_gr"}, 32'(uiGoRice_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_sig = 1'b0; cmd_cg_start = 1'b0; initial_gr = 3'd0;
    bin_valid = 1'b0; bin = 1'b0; lvl_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");
    model_reset();

    // Insignificant coefficient with CG reload: level 0, GR loaded
    bq.delete(); pad_bq();
    do_coef(1'b1, 1, 1'b0, 1'b0, 0);
    // greater1 = 0: level 1, c1 1->2
    bq = '{1'b0}; pad_bq();
    do_coef(1'b1, 0, 1'b1, 1'b0, 0);
    // greater1 = 1, greater2 = 0: level 2
    bq = '{1'b1, 1'b0}; pad_bq();
    do_coef(1'b0, 0, 1'b1, 1'b0, 0);
    // greater2 budget spent: base 2, prefix 2 -> level 4, GR 0->1
    bq = '{1'b1, 1'b1, 1'b1, 1'b0}; pad_bq();
    do_coef(1'b0, 0, 1'b1, 1'b0, 0);
    // Exhaust the greater1 budget
    for (int i = 0; i < 5; i++) begin
      bq = '{1'b0}; pad_bq();
      do_coef(1'b0, 0, 1'b1, 1'b0, 0);
    end
    // Escape-only path: prefix 4, two suffix bits -> level 11, GR 1->2
    bq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; pad_bq();
    do_coef(1'b0, 0, 1'b1, 1'b0, 0);
    // Stalled bins and downstream back-pressure
    bq = '{1'b1, 1'b0, 1'b1, 1'b1}; pad_bq();
    do_coef(1'b0, 0, 1'b1, 1'b1, 5);
    // Prefix overflow: error beat, contexts untouched
    bq.delete();
    for (int i = 0; i < 14; i++) bq.push_back(1'b1);
    pad_bq();
    do_coef(1'b1, 0, 1'b1, 1'b0, 0);

    // Reset in the middle of a prefix run drops the coefficient
    cmd_valid = 1'b1; cmd_sig = 1'b1; cmd_cg_start = 1'b1; initial_gr = 3'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_cg_start = 1'b0;
    bin = 1'b1; bin_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("mid_prefix_bin_ready", 32'(bin_ready), 32'd1);
    b0 = beats;
    rst = 1'b1; bin_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("midrst");
    repeat (3) begin @(posedge clk); #1; end
    check("midrst_no_beat", 32'(beats), 32'(b0));
    model_reset();

    // Random coefficients, stalls and back-pressure
    for (int n = 0; n < 60; n++) begin
      bq.delete();
      for (int i = 0; i < 40; i++) bq.push_back(1'($urandom));
      do_coef(($urandom % 8) == 0, int'($urandom % 5), ($urandom % 4) != 0,
              ($urandom % 5) == 0, (($urandom % 6) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
